// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide unit: datapath width, iteration
// counter width, md_op encodings and the FSM state type.
// Optional feature macro: MDU_DIV_EN (enables the divider in mdu).
// -----------------------------------------------------------------------------
package mdu_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 5;

   // md_op encodings; codes 3'd6 and 3'd7 are no-ops
   localparam logic [2:0] mult_op  = 3'd0;
   localparam logic [2:0] multu_op = 3'd1;
   localparam logic [2:0] div_op   = 3'd2;
   localparam logic [2:0] divu_op  = 3'd3;
   localparam logic [2:0] mthi_op  = 3'd4;
   localparam logic [2:0] mtlo_op  = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// -----------------------------------------------------------------------------
// mdu_div_step
// One combinational restoring-division step. The partial remainder is shifted
// left by one, pulling in the next dividend bit from the top of quo; if the
// divisor fits it is subtracted and a 1 is shifted into the quotient,
// otherwise the shifted remainder is kept and a 0 is shifted in.
// Ports:
//   rem     in  DATA_W  current partial remainder
//   quo     in  DATA_W  dividend bits still to consume / quotient built so far
//   dvs     in  DATA_W  divisor (magnitude)
//   rem_nxt out DATA_W  next partial remainder
//   quo_nxt out DATA_W  next quotient/dividend shift register
// Only instantiated when MDU_DIV_EN is defined.
// -----------------------------------------------------------------------------
module mdu_div_step
   import mdu_pkg::*;
(
   input  logic [DATA_W-1:0] rem,
   input  logic [DATA_W-1:0] quo,
   input  logic [DATA_W-1:0] dvs,
   output logic [DATA_W-1:0] rem_nxt,
   output logic [DATA_W-1:0] quo_nxt
);

   logic [DATA_W:0]   rem_sh;
   logic [DATA_W-1:0] diff;
   logic              fits;

   assign rem_sh = {rem, quo[DATA_W-1]};
   assign fits   = (rem_sh >= {1'b0, dvs});
   // When the divisor fits the true difference is below 2**DATA_W, so the
   // truncated subtraction is exact.
   assign diff   = rem_sh[DATA_W-1:0] - dvs;

   always_comb begin
      if (fits) begin
         rem_nxt = diff;
         quo_nxt = {quo[DATA_W-2:0], 1'b1};
      end else begin
         rem_nxt = rem_sh[DATA_W-1:0];
         quo_nxt = {quo[DATA_W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu
// Iterative multiply/divide unit with private HI/LO registers. Executes
// mult, multu, div, divu, mthi, mtlo. Multiplies take MUL_LAT busy cycles;
// divides use a 32-cycle radix-2 restoring loop plus a sign fix-up cycle.
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous reset, active-low
//   start  in   1   request, sampled only in IDLE
//   md_op  in   3   operation code (see mdu_pkg)
//   a      in  32   rs operand (dividend / multiplicand / mthi-mtlo source)
//   b      in  32   rt operand (divisor / multiplier)
//   busy   out  1   operation in flight (registered)
//   done   out  1   one-cycle pulse in the cycle HI/LO show a new result
//   hi     out 32   HI register
//   lo     out 32   LO register
// Parameter MUL_LAT (1..4): busy cycles for mult/multu.
// Macro MDU_DIV_EN: when defined the divider is built; when undefined
// div/divu complete in one cycle and leave HI/LO unchanged.
// -----------------------------------------------------------------------------
module mdu
   import mdu_pkg::*;
#(
   parameter int MUL_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2:0]        md_op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   mdu_state_e        state_q, state_n;
   logic [CNT_W-1:0]  cnt_q, cnt_n;
   logic              busy_q, done_q;
   logic [DATA_W-1:0] hi_q, hi_n;
   logic [DATA_W-1:0] lo_q, lo_n;
   logic              cap_mul;

   // multiplier operands, held stable for the whole MUL phase
   logic [DATA_W-1:0]          op_a_q, op_b_q;
   logic                       op_sgn_q;
   logic signed [2*DATA_W-1:0] mul_a, mul_b, prod;

   // Sign-extend (signed) or zero-extend (unsigned) to 64 bits; the low 64
   // bits of the 64x64 product are then correct for both flavours.
   assign mul_a = {{DATA_W{op_sgn_q & op_a_q[DATA_W-1]}}, op_a_q};
   assign mul_b = {{DATA_W{op_sgn_q & op_b_q[DATA_W-1]}}, op_b_q};
   assign prod  = mul_a * mul_b;

`ifdef MDU_DIV_EN
   logic              cap_div;
   logic              div_sgn;
   logic [DATA_W-1:0] abs_a, abs_b;
   logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
   logic [DATA_W-1:0] rem_nxt, quo_nxt;
   logic              q_neg_q, r_neg_q;

   assign div_sgn = (md_op == div_op);
   // 0x8000_0000 maps to itself, which is its correct unsigned magnitude
   assign abs_a   = (div_sgn && a[DATA_W-1]) ? -a : a;
   assign abs_b   = (div_sgn && b[DATA_W-1]) ? -b : b;

   mdu_div_step u_div_step (
      .rem     (rem_q),
      .quo     (quo_q),
      .dvs     (dvs_q),
      .rem_nxt (rem_nxt),
      .quo_nxt (quo_nxt)
   );
`endif

   // next-state and HI/LO update selection
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      hi_n    = hi_q;
      lo_n    = lo_q;
      cap_mul = 1'b0;
`ifdef MDU_DIV_EN
      cap_div = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (md_op)
                  mult_op, multu_op: begin
                     state_n = ST_MUL;
                     cnt_n   = '0;
                     cap_mul = 1'b1;
                  end
                  div_op, divu_op: begin
`ifdef MDU_DIV_EN
                     if (b == '0) begin
                        state_n = ST_DONE;
                        hi_n    = a;
                        lo_n    = '1;
                     end else begin
                        state_n = ST_DIV;
                        cnt_n   = '0;
                        cap_div = 1'b1;
                     end
`else
                     state_n = ST_DONE;
`endif
                  end
                  mthi_op: hi_n = a;
                  mtlo_op: lo_n = a;
                  default: ;
               endcase
            end
         end
         ST_MUL: begin
            if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
               state_n = ST_DONE;
               cnt_n   = '0;
               hi_n    = prod[2*DATA_W-1:DATA_W];
               lo_n    = prod[DATA_W-1:0];
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
`ifdef MDU_DIV_EN
         ST_DIV: begin
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
               state_n = ST_FIX;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         ST_FIX: begin
            state_n = ST_DONE;
            lo_n    = q_neg_q ? -quo_q : quo_q;
            hi_n    = r_neg_q ? -rem_q : rem_q;
         end
`endif
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // control and architectural registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         busy_q  <= (state_n == ST_MUL) || (state_n == ST_DIV) ||
                    (state_n == ST_FIX);
         done_q  <= (state_n == ST_DONE);
         hi_q    <= hi_n;
         lo_q    <= lo_n;
      end
   end

   // operand capture (data only, no reset needed)
   always_ff @(posedge clk) begin
      if (cap_mul) begin
         op_a_q   <= a;
         op_b_q   <= b;
         op_sgn_q <= (md_op == mult_op);
      end
   end

`ifdef MDU_DIV_EN
   // divider shift registers: loaded on accept, stepped once per DIV cycle
   always_ff @(posedge clk) begin
      if (cap_div) begin
         rem_q   <= '0;
         quo_q   <= abs_a;
         dvs_q   <= abs_b;
         q_neg_q <= div_sgn & (a[DATA_W-1] ^ b[DATA_W-1]);
         r_neg_q <= div_sgn & a[DATA_W-1];
      end else if (state_q == ST_DIV) begin
         rem_q <= rem_nxt;
         quo_q <= quo_nxt;
      end
   end
`endif

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// -----------------------------------------------------------------------------
// tb_mdu
// Directed bench for mdu (MUL_LAT = 2). Expected HI/LO and completion latency
// are queued when each request is driven and popped when done is seen.
// Divide expectations follow MDU_DIV_EN: with the divider built they are the
// arithmetic results; without it div/divu must leave HI/LO untouched and
// finish one cycle after acceptance.
// -----------------------------------------------------------------------------
module tb_mdu;
   import mdu_pkg::*;

`ifdef MDU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int          checks;
   int          errors;
   exp_t        sb[$];
   logic [31:0] m_hi, m_lo;

   mdu #(.MUL_LAT(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .md_op (md_op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no end of run, required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one request, follow it to done, compare against the queued result.
   task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eh, input logic [31:0] el, input int lat,
                         input int inject_at, input string tag);
      exp_t        e;
      int          k;
      logic [31:0] hi0, lo0;
      @(negedge clk);
      start = 1'b1;
      md_op = op;
      a     = av;
      b     = bv;
      e.hi  = eh;
      e.lo  = el;
      e.lat = lat;
      sb.push_back(e);
      hi0   = hi;
      lo0   = lo;
      @(posedge clk);
      k = 0;
      while (k < 200) begin
         @(negedge clk);
         k++;
         if (k == inject_at) begin
            start = 1'b1;
            md_op = mult_op;
            a     = 32'h0000_0007;
            b     = 32'h0000_0009;
         end else begin
            start = 1'b0;
         end
         if (done) break;
         check({tag, "_busy"}, {31'd0, busy}, 32'd1);
         check({tag, "_hi_hold"}, hi, hi0);
         check({tag, "_lo_hold"}, lo, lo0);
      end
      start = 1'b0;
      check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
      e = sb.pop_front();
      check({tag, "_latency"}, 32'(k), 32'(e.lat));
      check({tag, "_hi"}, hi, e.hi);
      check({tag, "_lo"}, lo, e.lo);
      check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      m_hi = e.hi;
      m_lo = e.lo;
   endtask

   task automatic run_div(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eh, input logic [31:0] el, input int lat,
                          input int inject_at, input string tag);
      if (DIV_EN) run_op(op, av, bv, eh, el, lat, inject_at, tag);
      else        run_op(op, av, bv, m_hi, m_lo, 1, inject_at, tag);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_hi   = '0;
      m_lo   = '0;
      rst_n  = 1'b0;
      start  = 1'b0;
      md_op  = mult_op;
      a      = '0;
      b      = '0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      rst_n = 1'b1;

      // multiplies
      run_op(mult_op,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 3, 0, "mult_s");
      run_op(multu_op, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 3, 0, "multu");
      run_op(multu_op, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 3, 0, "multu_carry");
      run_op(mult_op,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 3, 0, "mult_minmin");

      // divides
      run_div(div_op,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 0, "div_s");
      run_div(divu_op, 32'd100, 32'd7, 32'd2, 32'd14, 34, 0, "divu");
      run_div(div_op,  32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1, 0, "div_zero");
      run_div(div_op,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34, 0, "div_ovf");
      // mult request pulsed in cycle E0+5 must be ignored
      run_div(div_op,  32'd1000, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FEB3, 34, 5, "div_inject");

      // mthi / mtlo
      @(negedge clk);
      start = 1'b1;
      md_op = mthi_op;
      a     = 32'h0000_A5A5;
      @(negedge clk);
      start = 1'b0;
      check("mthi_hi", hi, 32'h0000_A5A5);
      check("mthi_lo", lo, m_lo);
      check("mthi_busy", {31'd0, busy}, 32'd0);
      check("mthi_done", {31'd0, done}, 32'd0);
      m_hi = 32'h0000_A5A5;
      start = 1'b1;
      md_op = mtlo_op;
      a     = 32'h0000_5A5A;
      @(negedge clk);
      start = 1'b0;
      check("mtlo_lo", lo, 32'h0000_5A5A);
      check("mtlo_hi", hi, m_hi);
      m_lo = 32'h0000_5A5A;

      // unknown op: nothing happens
      start = 1'b1;
      md_op = 3'd6;
      a     = 32'hDEAD_BEEF;
      b     = 32'd5;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("noop_busy", {31'd0, busy}, 32'd0);
      check("noop_done", {31'd0, done}, 32'd0);
      check("noop_hi", hi, m_hi);
      check("noop_lo", lo, m_lo);

      // reset in the middle of a long operation
      start = 1'b1;
      md_op = DIV_EN ? divu_op : multu_op;
      a     = 32'd100;
      b     = 32'd7;
      @(negedge clk);
      start = 1'b0;
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      repeat (DIV_EN ? 8 : 0) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_hi", hi, 32'd0);
      check("midrst_lo", lo, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      m_hi  = '0;
      m_lo  = '0;
      run_op(mult_op, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 3, 0, "post_rst_mult");
      run_div(divu_op, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF, 34, 0, "post_rst_divu");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
